// File: rtl/demux_4_pkg.sv
// -----------------------------------------------------------------------------
// demux_4_pkg
// Shared constants for the 4-way buffered demultiplexer: default data width,
// channel count, derived select/counter widths and a population-count helper.
// -----------------------------------------------------------------------------
package demux_4_pkg;

  localparam int REG_W  = 32;                  // default data word width
  localparam int NUM_CH = 4;                   // number of output channels
  localparam int SEL_W  = $clog2(NUM_CH);      // channel select width
  localparam int CNT_W  = $clog2(NUM_CH + 1);  // holds 0..NUM_CH

  // Number of set bits in a channel vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage : demux_4_pkg

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry holding slot for a single output channel: a full flag plus a data
// register. A load always wins over a drain, so a slot that is drained and
// loaded on the same edge stays full with the new word (no bubble).
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   load_i       write load_data_i into the slot this edge
//   drain_i      sink takes the held word this edge (no effect when empty)
//   load_data_i  word to store
//   full_o       slot holds a word
//   data_o       held word
// -----------------------------------------------------------------------------
module demux_slot
  import demux_4_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic [W-1:0] load_data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    full_d = full_q;
    data_d = data_q;
    if (drain_i) full_d = 1'b0;
    if (load_i) begin
      full_d = 1'b1;
      data_d = load_data_i;
    end
  end

  // NOTE: the data register is a plain flop, not a memory array, so it takes
  // the async reset like the flag and a cleared channel drives zeros.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule : demux_slot

// File: rtl/demux_4.sv
// -----------------------------------------------------------------------------
// demux_4
// Buffered 1-to-4 demultiplexer. Each channel owns a one-entry slot; a word
// presented with iValid is routed to slot iSel and is accepted when that slot
// is empty or is being drained by its sink on the same edge.
//
// Ports
//   iClk          clock, rising edge
//   iReset_n      asynchronous active-low reset
//   iValid        source presents a word
//   oReady        block accepts the presented word this cycle (combinational)
//   iSel          destination channel 0..3
//   iData         presented word
//   oValid[k]     channel k holds a word
//   iReady[k]     sink k takes channel k's word this cycle
//   oZeroBranch .. oThreeBranch   channel 0..3 data
//   oPending      registered count of full channels (0..4)
// -----------------------------------------------------------------------------
module demux_4
  import demux_4_pkg::*;
#(
  parameter int DATA_WIDTH = REG_W
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [SEL_W-1:0]      iSel,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic [NUM_CH-1:0]     oValid,
  input  logic [NUM_CH-1:0]     iReady,
  output logic [DATA_WIDTH-1:0] oZeroBranch,
  output logic [DATA_WIDTH-1:0] oOneBranch,
  output logic [DATA_WIDTH-1:0] oTwoBranch,
  output logic [DATA_WIDTH-1:0] oThreeBranch,
  output logic [CNT_W-1:0]      oPending
);

  logic [NUM_CH-1:0]     full;
  logic [NUM_CH-1:0]     load;
  logic [NUM_CH-1:0]     full_next;
  logic [DATA_WIDTH-1:0] slot_data [NUM_CH];
  logic                  accept;
  logic [CNT_W-1:0]      pending_q, pending_d;

  // Slots are cleared by reset, so oReady reads 1 while iReset_n is low.
  assign oReady = ~full[iSel] | iReady[iSel];
  assign accept = iValid & oReady;

  always_comb begin
    load       = '0;
    load[iSel] = accept;
  end

  // Mirrors the slot update so the count is registered alongside the flags.
  assign full_next = load | (full & ~iReady);
  assign pending_d = popcount(full_next);

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) pending_q <= '0;
    else           pending_q <= pending_d;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.W(DATA_WIDTH)) u_slot (
      .clk_i       (iClk),
      .rst_ni      (iReset_n),
      .load_i      (load[k]),
      .drain_i     (iReady[k]),
      .load_data_i (iData),
      .full_o      (full[k]),
      .data_o      (slot_data[k])
    );
  end

  assign oValid       = full;
  assign oPending     = pending_q;
  assign oZeroBranch  = slot_data[0];
  assign oOneBranch   = slot_data[1];
  assign oTwoBranch   = slot_data[2];
  assign oThreeBranch = slot_data[3];

endmodule : demux_4

// File: tb/tb_demux_4.sv
// -----------------------------------------------------------------------------
// tb_demux_4
// Scoreboard bench for demux_4: the driver pushes each accepted word onto a
// per-channel expected queue; a monitor pops and compares whenever a channel
// hands a word to its sink, and cross-checks oValid/oPending against the
// queue occupancy every cycle.
// -----------------------------------------------------------------------------
module tb_demux_4;
  import demux_4_pkg::*;

  localparam int W = 32;

  logic          iClk = 1'b0;
  logic          iReset_n;
  logic          iValid;
  logic          oReady;
  logic [1:0]    iSel;
  logic [W-1:0]  iData;
  logic [3:0]    oValid;
  logic [3:0]    iReady;
  logic [W-1:0]  oZeroBranch, oOneBranch, oTwoBranch, oThreeBranch;
  logic [2:0]    oPending;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q [4][$];
  int           drained [4];

  always #5 iClk = ~iClk;

  demux_4 #(.DATA_WIDTH(W)) dut (
    .iClk         (iClk),
    .iReset_n     (iReset_n),
    .iValid       (iValid),
    .oReady       (oReady),
    .iSel         (iSel),
    .iData        (iData),
    .oValid       (oValid),
    .iReady       (iReady),
    .oZeroBranch  (oZeroBranch),
    .oOneBranch   (oOneBranch),
    .oTwoBranch   (oTwoBranch),
    .oThreeBranch (oThreeBranch),
    .oPending     (oPending)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] branch(input int k);
    case (k)
      0:       return oZeroBranch;
      1:       return oOneBranch;
      2:       return oTwoBranch;
      default: return oThreeBranch;
    endcase
  endfunction

  function automatic int queued_total();
    int t = 0;
    for (int k = 0; k < 4; k++) t += exp_q[k].size();
    return t;
  endfunction

  // Source protocol: a stalled word may be withdrawn but not altered.
  assert property (@(posedge iClk) disable iff (!iReset_n)
    (iValid && !oReady) |=> (!iValid || ($stable(iSel) && $stable(iData))))
  else begin
    n_err++;
    $display("FAIL source_hold: iSel/iData changed while stalled");
  end

  // Drive one cycle at the falling edge, then record an acceptance just
  // before the rising edge.
  task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                      input logic [3:0] r);
    @(negedge iClk);
    iValid = v;
    iSel   = s;
    iData  = d;
    iReady = r;
    #4;
    if (iReset_n && iValid && oReady) exp_q[s].push_back(d);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) exp_q[k].delete();
  endtask

  // Monitor: 3 time units after the falling edge, before the driver's sample.
  initial begin
    forever begin
      @(negedge iClk);
      #3;
      if (iReset_n === 1'b1) begin
        check("pending_vs_model", {29'd0, oPending}, queued_total());
        for (int k = 0; k < 4; k++) begin
          check($sformatf("valid_ch%0d", k), {31'd0, oValid[k]}, {31'd0, exp_q[k].size() != 0});
          if (oValid[k] && iReady[k]) begin
            if (exp_q[k].size() == 0) begin
              check($sformatf("unexpected_word_ch%0d", k), branch(k), 32'hFFFF_FFFF ^ branch(k));
            end else begin
              check($sformatf("data_ch%0d", k), branch(k), exp_q[k].pop_front());
            end
            drained[k]++;
          end
        end
      end
    end
  end

  initial begin
    int base;
    logic          v;
    logic [1:0]    s;
    logic [W-1:0]  d;

    for (int k = 0; k < 4; k++) drained[k] = 0;
    iReset_n = 1'b0;
    iValid   = 1'b0;
    iSel     = '0;
    iData    = '0;
    iReady   = '0;

    // Reset state; a word offered during reset must not be registered.
    step(1'b1, 2'd2, 32'h0000_CAFE, 4'h0);
    check("rst_ready", {31'd0, oReady}, 32'd1);
    check("rst_valid", {28'd0, oValid}, 32'd0);
    check("rst_pending", {29'd0, oPending}, 32'd0);
    check("rst_data0", oZeroBranch, 32'd0);
    check("rst_data2", oTwoBranch, 32'd0);
    step(1'b1, 2'd2, 32'h0000_CAFE, 4'h0);
    check("rst_no_accept", {28'd0, oValid}, 32'd0);
    step(1'b0, 2'd0, 32'd0, 4'h0);
    iReset_n = 1'b1;

    // Single word to channel 2, then a repeat that must stall.
    step(1'b1, 2'd2, 32'hDEAD_BEEF, 4'h0);
    check("w1_ready", {31'd0, oReady}, 32'd1);
    step(1'b1, 2'd2, 32'h1234_5678, 4'h0);
    check("w1_valid", {28'd0, oValid}, 32'h4);
    check("w1_data", oTwoBranch, 32'hDEAD_BEEF);
    check("w1_pending", {29'd0, oPending}, 32'd1);
    check("w1_stall", {31'd0, oReady}, 32'd0);
    step(1'b0, 2'd0, 32'd0, 4'h0);
    check("w1_hold", oTwoBranch, 32'hDEAD_BEEF);
    step(1'b0, 2'd0, 32'd0, 4'h4);
    step(1'b0, 2'd0, 32'd0, 4'h0);
    check("w1_drained", {28'd0, oValid}, 32'd0);

    // Drain and reload channel 1 on the same edge.
    step(1'b1, 2'd1, 32'h1111_0000, 4'h0);
    step(1'b1, 2'd1, 32'h1111_0001, 4'h2);
    check("pass_ready", {31'd0, oReady}, 32'd1);
    step(1'b0, 2'd0, 32'd0, 4'h0);
    check("pass_valid", {31'd0, oValid[1]}, 32'd1);
    check("pass_data", oOneBranch, 32'h1111_0001);
    check("pass_pending", {29'd0, oPending}, 32'd1);
    step(1'b0, 2'd0, 32'd0, 4'h2);

    // Fill all four channels with nobody draining.
    for (int k = 0; k < 4; k++) step(1'b1, 2'(k), 32'hA0 + 32'(k), 4'h0);
    step(1'b0, 2'd0, 32'd0, 4'h0);
    check("fill_valid", {28'd0, oValid}, 32'hF);
    check("fill_pending", {29'd0, oPending}, 32'd4);
    check("fill_d0", oZeroBranch, 32'hA0);
    check("fill_d3", oThreeBranch, 32'hA3);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'(k), 32'd0, 4'h0);
      check($sformatf("fill_ready_sel%0d", k), {31'd0, oReady}, 32'd0);
    end
    step(1'b0, 2'd0, 32'd0, 4'hF);
    step(1'b0, 2'd0, 32'd0, 4'hF);
    check("fill_empty", {28'd0, oValid}, 32'd0);
    check("empty_ready_ignored", {29'd0, oPending}, 32'd0);

    // Ten back-to-back words streamed through channel 3.
    base = drained[3];
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'd3, 32'h3000 + 32'(i), 4'h8);
      check("stream_ready", {31'd0, oReady}, 32'd1);
      if (i > 0) check("stream_pending", {29'd0, oPending}, 32'd1);
    end
    step(1'b0, 2'd0, 32'd0, 4'h8);
    step(1'b0, 2'd0, 32'd0, 4'h0);
    check("stream_count", 32'(drained[3] - base), 32'd10);

    // Asynchronous reset in the middle of a cycle with channels 0 and 3 full.
    step(1'b1, 2'd0, 32'h0000_00C0, 4'h0);
    step(1'b1, 2'd3, 32'h0000_00C3, 4'h0);
    step(1'b0, 2'd0, 32'd0, 4'h0);
    check("mid_valid_pre", {28'd0, oValid}, 32'h9);
    #3;
    iReset_n = 1'b0;
    #1;
    check("async_valid", {28'd0, oValid}, 32'd0);
    check("async_pending", {29'd0, oPending}, 32'd0);
    check("async_d3", oThreeBranch, 32'd0);
    clear_model();
    step(1'b1, 2'd3, 32'h0000_0BAD, 4'h8);
    check("async_ready", {31'd0, oReady}, 32'd1);
    step(1'b0, 2'd0, 32'd0, 4'h0);
    iReset_n = 1'b1;
    step(1'b0, 2'd0, 32'd0, 4'hF);
    step(1'b0, 2'd0, 32'd0, 4'h0);
    check("post_rst_valid", {28'd0, oValid}, 32'd0);
    check("post_rst_d0", oZeroBranch, 32'd0);

    // Random traffic against the per-channel scoreboard.
    v = 1'b0;
    s = '0;
    d = '0;
    for (int i = 0; i < 10000; i++) begin
      if (iValid && !oReady) begin
        if ($urandom_range(0, 7) == 0) v = 1'b0;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = $urandom;
      end
      step(v, s, d, 4'($urandom_range(0, 15)));
    end
    step(1'b0, 2'd0, 32'd0, 4'hF);
    step(1'b0, 2'd0, 32'd0, 4'hF);
    step(1'b0, 2'd0, 32'd0, 4'h0);
    check("final_queue_empty", 32'(queued_total()), 32'd0);
    check("final_valid", {28'd0, oValid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_demux_4
